// File: rtl/resp_capture_checker_if.sv
// Response-capture bus: sweep control, circuit-under-test hookup and results.
//   start        - request a new sweep (from the controller)
//   golden       - expected truth table, bit v is the expected value for vector v
//   dut_out      - output of the circuit under test
//   vec_out      - vector currently applied to the circuit under test
//   busy, done   - sweep in progress / sweep complete (held)
//   resp         - captured response, bit v is the sample for vector v
//   mismatch_cnt - number of vectors whose sample differed from golden
//   fail         - at least one mismatch
//   first_fail   - lowest mismatching vector (0 when fail=0)
// master: the side that starts sweeps and hosts the circuit; slave: the engine.
interface resp_capture_checker_if #(
  parameter int N_IN = 5
);
  localparam int NV = 1 << N_IN;

  logic            start;
  logic [NV-1:0]   golden;
  logic            dut_out;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic [NV-1:0]   resp;
  logic [N_IN:0]   mismatch_cnt;
  logic            fail;
  logic [N_IN-1:0] first_fail;

  modport master (
    output start, golden, dut_out,
    input  vec_out, busy, done, resp, mismatch_cnt, fail, first_fail
  );

  modport slave (
    input  start, golden, dut_out,
    output vec_out, busy, done, resp, mismatch_cnt, fail, first_fail
  );
endinterface

// File: rtl/resp_capture_checker.sv
// Exhaustive response-capture and compare engine. Sweeps all 2^N_IN input
// vectors of a single-output circuit, holds each for SETTLE+1 cycles, samples
// the circuit output at the end of the hold and compares it with a golden
// truth table latched at start.
// Ports:
//   CK    - clock, all state changes on the rising edge
//   reset - synchronous active-high reset
//   bus   - slave side of resp_capture_checker_if (start/golden/dut_out in,
//           vec_out/busy/done/resp/mismatch_cnt/fail/first_fail out)
// All outputs come straight from registers.
module resp_capture_checker #(
  parameter int N_IN   = 5,
  parameter int SETTLE = 1
) (
  input  logic                  CK,
  input  logic                  reset,
  resp_capture_checker_if.slave bus
);

  localparam int NV    = 1 << N_IN;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [N_IN-1:0]  vec_r, vec_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [NV-1:0]    golden_r, golden_s;
  logic [NV-1:0]    resp_r, resp_s;
  logic [N_IN:0]    mcnt_r, mcnt_s;
  logic             fail_r, fail_s;
  logic [N_IN-1:0]  ffail_r, ffail_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  // State and result registers; reset returns everything, including golden, to 0.
  always_ff @(posedge CK) begin
    if (reset) begin
      state_r  <= IDLE;
      vec_r    <= '0;
      cnt_r    <= '0;
      golden_r <= '0;
      resp_r   <= '0;
      mcnt_r   <= '0;
      fail_r   <= 1'b0;
      ffail_r  <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      vec_r    <= vec_s;
      cnt_r    <= cnt_s;
      golden_r <= golden_s;
      resp_r   <= resp_s;
      mcnt_r   <= mcnt_s;
      fail_r   <= fail_s;
      ffail_r  <= ffail_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  // Next-state and next-result logic for the sweep.
  always_comb begin
    state_s  = state_r;
    vec_s    = vec_r;
    cnt_s    = cnt_r;
    golden_s = golden_r;
    resp_s   = resp_r;
    mcnt_s   = mcnt_r;
    fail_s   = fail_r;
    ffail_s  = ffail_r;
    busy_s   = busy_r;
    done_s   = done_r;

    case (state_r)
      IDLE, DONE: begin
        // start is only honoured here, so a pulse during a sweep is harmless
        if (bus.start) begin
          state_s  = APPLY;
          golden_s = bus.golden;
          resp_s   = '0;
          mcnt_s   = '0;
          fail_s   = 1'b0;
          ffail_s  = '0;
          vec_s    = '0;
          cnt_s    = '0;
          busy_s   = 1'b1;
          done_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      APPLY: begin
        if (cnt_r == CNT_LAST) begin
          state_s = SAMPLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end

      SAMPLE: begin
        resp_s[vec_r] = bus.dut_out;
        if (bus.dut_out != golden_r[vec_r]) begin
          // N_IN+1 bits hold 2^N_IN, so the count cannot wrap
          mcnt_s = mcnt_r + {{N_IN{1'b0}}, 1'b1};
          if (!fail_r) begin
            fail_s  = 1'b1;
            ffail_s = vec_r;
          end else begin
            ffail_s = ffail_r;
          end
        end else begin
          mcnt_s = mcnt_r;
        end

        if (vec_r == VEC_LAST) begin
          // vec_out stays on the last vector while results are held
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          state_s = APPLY;
          vec_s   = vec_r + N_IN'(1'b1);
          cnt_s   = '0;
        end
      end

      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  assign bus.vec_out      = vec_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.resp         = resp_r;
  assign bus.mismatch_cnt = mcnt_r;
  assign bus.fail         = fail_r;
  assign bus.first_fail   = ffail_r;

endmodule

// File: tb/tb_resp_capture_checker.sv
// Bench for resp_capture_checker: two instances (N_IN=5/SETTLE=1 and
// N_IN=3/SETTLE=3), a cycle-count reference model of the sweep, a per-cycle
// compare process and directed scenarios with literal expectations.
module tb_resp_capture_checker;

  logic CK;
  logic reset;

  resp_capture_checker_if #(.N_IN(5)) if0 ();
  resp_capture_checker_if #(.N_IN(3)) if1 ();

  resp_capture_checker #(.N_IN(5), .SETTLE(1)) dut0 (.CK(CK), .reset(reset), .bus(if0));
  resp_capture_checker #(.N_IN(3), .SETTLE(3)) dut1 (.CK(CK), .reset(reset), .bus(if1));

  int vectors;
  int miscompares;
  bit chk_en;

  logic        start_d  [2];
  logic [31:0] golden_d [2];
  int          mode_d   [2];

  // per-instance geometry: number of vectors and cycles per vector
  int nv [2];
  int sp [2];

  // circuit under test: 0=AND, 1=NAND, 2=AND with vector 19 flipped, 3=OR
  function automatic logic circ(input int mode, input int v, input int n);
    case (mode)
      0:       return v == n - 1;
      1:       return v != n - 1;
      2:       return (v == n - 1) ^ (v == 19);
      default: return v != 0;
    endcase
  endfunction

  assign if0.start   = start_d[0];
  assign if0.golden  = golden_d[0];
  assign if0.dut_out = circ(mode_d[0], int'(if0.vec_out), 32);
  assign if1.start   = start_d[1];
  assign if1.golden  = golden_d[1][7:0];
  assign if1.dut_out = circ(mode_d[1], int'(if1.vec_out), 8);

  logic [31:0] vec_w [2], resp_w [2], cnt_w [2], ff_w [2];
  logic        busy_w [2], done_w [2], fail_w [2];

  assign vec_w[0]  = 32'(if0.vec_out);
  assign resp_w[0] = 32'(if0.resp);
  assign cnt_w[0]  = 32'(if0.mismatch_cnt);
  assign ff_w[0]   = 32'(if0.first_fail);
  assign busy_w[0] = if0.busy;
  assign done_w[0] = if0.done;
  assign fail_w[0] = if0.fail;
  assign vec_w[1]  = 32'(if1.vec_out);
  assign resp_w[1] = 32'(if1.resp);
  assign cnt_w[1]  = 32'(if1.mismatch_cnt);
  assign ff_w[1]   = 32'(if1.first_fail);
  assign busy_w[1] = if1.busy;
  assign done_w[1] = if1.done;
  assign fail_w[1] = if1.fail;

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d at %0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 sweeping (m_n edges since the start edge), 2 done.
  int          m_phase [2];
  int          m_n     [2];
  logic [31:0] m_gold  [2];
  int          m_mode  [2];

  always @(posedge CK) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_phase[d] <= 0;
        m_n[d]     <= 0;
        m_gold[d]  <= 32'h0;
      end else if (m_phase[d] != 1 && start_d[d]) begin
        m_phase[d] <= 1;
        m_n[d]     <= 0;
        m_gold[d]  <= golden_d[d];
        m_mode[d]  <= mode_d[d];
      end else if (m_phase[d] == 1) begin
        m_n[d] <= m_n[d] + 1;
        if (m_n[d] + 1 == nv[d] * sp[d]) m_phase[d] <= 2;
      end
    end
  end

  // Compare every output of both instances against the model on each falling edge.
  always @(negedge CK) begin : cmp
    int c, e_vec, e_cnt, e_ff;
    logic e_busy, e_done, e_fail, b;
    logic [31:0] e_resp;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        if (m_phase[d] == 1) begin
          c = m_n[d] / sp[d]; e_vec = c; e_busy = 1'b1; e_done = 1'b0;
        end else if (m_phase[d] == 2) begin
          c = nv[d]; e_vec = nv[d] - 1; e_busy = 1'b0; e_done = 1'b1;
        end else begin
          c = 0; e_vec = 0; e_busy = 1'b0; e_done = 1'b0;
        end
        e_resp = 32'h0; e_cnt = 0; e_ff = 0; e_fail = 1'b0;
        for (int v = 0; v < c; v++) begin
          b = circ(m_mode[d], v, nv[d]);
          e_resp[v] = b;
          if (b != m_gold[d][v]) begin
            e_cnt++;
            if (!e_fail) begin
              e_fail = 1'b1;
              e_ff = v;
            end
          end
        end
        chk("vec_out", d, vec_w[d], 32'(e_vec));
        chk("busy", d, 32'(busy_w[d]), 32'(e_busy));
        chk("done", d, 32'(done_w[d]), 32'(e_done));
        chk("resp", d, resp_w[d], e_resp);
        chk("mismatch_cnt", d, cnt_w[d], 32'(e_cnt));
        chk("fail", d, 32'(fail_w[d]), 32'(e_fail));
        chk("first_fail", d, ff_w[d], 32'(e_ff));
      end
    end
  end

  task automatic run_sweep(input int d, input int mode, input logic [31:0] gold,
                           input int disturb_vec, output int busy_cyc, output int hold2);
    int k;
    bit pulsed;
    @(negedge CK);
    golden_d[d] = gold;
    mode_d[d]   = mode;
    start_d[d]  = 1'b1;
    @(negedge CK);
    start_d[d] = 1'b0;
    chk("done_low_after_start", d, 32'(done_w[d]), 32'd0);
    busy_cyc = 0; hold2 = 0; pulsed = 1'b0; k = 0;
    while (k < 400 && !done_w[d]) begin
      if (busy_w[d]) busy_cyc++;
      if (busy_w[d] && vec_w[d] == 32'd2) hold2++;
      if (!pulsed && disturb_vec >= 0 && vec_w[d] == 32'(disturb_vec)) begin
        // stray start plus a golden change mid-sweep: both must be ignored
        start_d[d]  = 1'b1;
        golden_d[d] = 32'h0;
        pulsed = 1'b1;
      end else begin
        start_d[d] = 1'b0;
      end
      @(negedge CK);
      k++;
    end
    start_d[d] = 1'b0;
    chk("sweep_done", d, 32'(done_w[d]), 32'd1);
  endtask

  initial begin
    int bc, h2, k;
    vectors = 0; miscompares = 0; chk_en = 1'b0;
    nv[0] = 32; sp[0] = 2;
    nv[1] = 8;  sp[1] = 4;
    mode_d[0] = 0; mode_d[1] = 3;
    golden_d[0] = 32'h0; golden_d[1] = 32'h0;
    m_mode[0] = 0; m_mode[1] = 3;

    // reset for two cycles with start held high on instance 0: start is ignored
    reset = 1'b1;
    start_d[0] = 1'b1; start_d[1] = 1'b0;
    repeat (2) @(posedge CK);
    @(negedge CK);
    chk("rst_busy_with_start", 0, 32'(busy_w[0]), 32'd0);
    reset = 1'b0;
    start_d[0] = 1'b0;
    chk_en = 1'b1;
    @(negedge CK);
    chk("idle_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("idle_done", 0, 32'(done_w[0]), 32'd0);
    chk("idle_vec", 0, vec_w[0], 32'd0);
    chk("idle_resp", 0, resp_w[0], 32'd0);
    chk("idle_resp", 1, resp_w[1], 32'd0);

    // pass case: AND against its own truth table
    run_sweep(0, 0, 32'h8000_0000, -1, bc, h2);
    chk("pass_busy_cycles", 0, 32'(bc), 32'd64);
    chk("pass_resp", 0, resp_w[0], 32'h8000_0000);
    chk("pass_cnt", 0, cnt_w[0], 32'd0);
    chk("pass_fail", 0, 32'(fail_w[0]), 32'd0);
    chk("pass_first_fail", 0, ff_w[0], 32'd0);

    // total fail: inverted AND
    run_sweep(0, 1, 32'h8000_0000, -1, bc, h2);
    chk("nand_resp", 0, resp_w[0], 32'h7FFF_FFFF);
    chk("nand_cnt", 0, cnt_w[0], 32'd32);
    chk("nand_fail", 0, 32'(fail_w[0]), 32'd1);
    chk("nand_first_fail", 0, ff_w[0], 32'd0);

    // single trojan hit on vector 19
    run_sweep(0, 2, 32'h8000_0000, -1, bc, h2);
    chk("trojan_resp", 0, resp_w[0], 32'h8008_0000);
    chk("trojan_cnt", 0, cnt_w[0], 32'd1);
    chk("trojan_first_fail", 0, ff_w[0], 32'd19);
    run_sweep(0, 2, 32'h8008_0000, -1, bc, h2);
    chk("trojan2_cnt", 0, cnt_w[0], 32'd0);
    chk("trojan2_fail", 0, 32'(fail_w[0]), 32'd0);

    // disturbance: start re-asserted (and golden changed) during vector 7
    run_sweep(0, 0, 32'h8000_0000, 7, bc, h2);
    chk("disturb_busy_cycles", 0, 32'(bc), 32'd64);
    chk("disturb_resp", 0, resp_w[0], 32'h8000_0000);
    chk("disturb_cnt", 0, cnt_w[0], 32'd0);

    // reset mid-sweep while vector 10 is applied
    @(negedge CK);
    golden_d[0] = 32'h8000_0000; mode_d[0] = 1; start_d[0] = 1'b1;
    @(negedge CK);
    start_d[0] = 1'b0;
    k = 0;
    while (k < 100 && vec_w[0] != 32'd10) begin
      @(negedge CK);
      k++;
    end
    chk("reached_vec10", 0, vec_w[0], 32'd10);
    chk("pre_reset_resp", 0, resp_w[0], 32'h0000_03FF);
    reset = 1'b1;
    @(negedge CK);
    reset = 1'b0;
    chk("midrst_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("midrst_done", 0, 32'(done_w[0]), 32'd0);
    chk("midrst_resp", 0, resp_w[0], 32'd0);
    chk("midrst_vec", 0, vec_w[0], 32'd0);

    // second geometry: N_IN=3, SETTLE=3, OR circuit
    run_sweep(1, 3, 32'h0000_00FE, -1, bc, h2);
    chk("or_busy_cycles", 1, 32'(bc), 32'd32);
    chk("or_hold_vec2", 1, 32'(h2), 32'd4);
    chk("or_resp", 1, resp_w[1], 32'h0000_00FE);
    chk("or_cnt", 1, cnt_w[1], 32'd0);
    chk("or_fail", 1, 32'(fail_w[1]), 32'd0);

    repeat (3) @(negedge CK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
